pipelined_addsub: RTL
=====================

// Module: pipelined_addsub
// PURPOSE
//   Parametrised, pipelined ripple-carry adder/subtractor. Successor to the 4-bit
//   combinational ripple adder.
//   - Splits a WIDTH-bit operation into STAGES equal ripple-carry chunks.
//   - Registers the carry between chunks.
//   - Accepts one operation per cycle under a valid/ready handshake.
//   Sits between operand-producing logic and any ALU or accumulator consumer.
// PARAMETERS
//   WIDTH   16  operand/result width in bits; must be a multiple of STAGES
//   STAGES  4   pipeline stages = ripple chunks; CHUNK = WIDTH/STAGES bits each; >=1
// PORTS
//   clk        in   1      single clock, all state updates on rising edge
//   rst_n      in   1      reset, asynchronous, active-low
//   in_valid   in   1      operand bundle valid
//   in_ready   out  1      block can accept a bundle this cycle
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_cin     in   1      carry-in (add) / borrow-in (sub)
//   in_sub     in   1      0 = A+B+cin, 1 = A-B-cin
//   out_valid  out  1      result bundle valid
//   out_ready  in   1      consumer accepts result this cycle
//   out_sum    out  WIDTH  result
//   out_cout   out  1      raw carry-out of MSB (sub: 1 = no borrow)
//   out_ovf    out  1      two's-complement signed overflow
// BEHAVIOUR
//   - Reset (async assert, sync release): all stage valid bits, out_valid,
//     out_sum, out_cout and out_ovf go to 0. Reset asserted mid-operation
//     discards all in-flight bundles; nothing is emitted after release.
//   - Operand conditioning at entry:
//     - B' = in_sub ? ~in_b : in_b
//     - carry_in = in_sub ? ~in_cin : in_cin
//   - Stage k (0..STAGES-1):
//     - Adds chunk k of A and B' plus the carry registered by stage k-1
//       (carry_in for k=0).
//     - Registers its sum chunk, its carry-out, and the not-yet-consumed upper
//       chunks of A and B'.
//     - Lower result chunks travel with the bundle.
//   - Latency: exactly STAGES cycles from accepted input to out_valid when
//     never stalled. STAGES=1 gives one registered full-width ripple.
//   - Stall rule:
//     - advance = !out_valid | out_ready
//     - in_ready = advance
//     - All stages move together on advance. Stage valid bits shift; bubbles
//       are not compressed.
//     - On !advance every stage register holds and the out_* values stay stable.
//   - Transfers: an input is accepted iff in_valid & in_ready. An output is
//     consumed iff out_valid & out_ready. Accept and consume may occur in the
//     same cycle, which sustains full throughput of 1 op/cycle.
//   - Flags:
//     - out_cout = carry-out of the final chunk.
//     - out_ovf = carry into MSB XOR carry out of MSB, computed in the final stage.
//   - Result is modulo 2^WIDTH; no saturation.
//   - Ordering: results emerge strictly in acceptance order; no drop, no duplicate.
//   - in_sub/in_cin are sampled only on acceptance and travel with the bundle,
//     so add and sub may be mixed on consecutive cycles.
// STRUCTURE
//   - Shared package adder_pkg: function chunk_w(WIDTH,STAGES); localparam for
//     the default widths.
//   - Sub-module rca_chunk #(CHUNK): purely combinational CHUNK-bit ripple adder
//     (a, b, cin -> sum, cout, c_msb_in) built from per-bit full-adder equations.
//     Instantiated STAGES times by a generate loop.
//   - Top holds the stage registers, skew registers and valid/stall logic.
// TESTING (WIDTH=16, STAGES=4 unless noted)
//   1. Add 0x1234 + 0x0FFF, cin=0, out_ready=1 -> out_sum=0x2233, cout=0,
//      ovf=0, out_valid exactly 4 cycles after acceptance.
//   2. Add 0xFFFF + 0x0001, cin=0 -> 0x0000, cout=1, ovf=0 (carry crosses all
//      stage boundaries).
//   3. Sub 0x8000 - 0x0001, cin=0 -> 0x7FFF, cout=1, ovf=1. Then sub
//      0x0000 - 0x0001 -> 0xFFFF, cout=0, ovf=0.
//   4. Stream 8 mixed add/sub ops on consecutive cycles; drop out_ready for
//      3 cycles mid-stream.
//      -> in_ready low during the stall; out_* stable while held.
//      -> All 8 results correct, in order, none lost.
//   5. Accept 3 ops, assert rst_n=0 asynchronously between edges.
//      -> out_valid=0 immediately; after release, no result appears until a
//         new op is accepted.
//   6. Config WIDTH=8, STAGES=1: add 0x7F + 0x01 -> 0x80, ovf=1, cout=0,
//      latency 1 cycle.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared sizing helpers for the pipelined adder/subtractor family.
// Default geometry plus the chunk-width calculation used by the top and the chunk adder.
package adder_pkg;
   localparam int DEF_WIDTH  = 16;
   localparam int DEF_STAGES = 4;

   function automatic int chunk_w(input int width, input int stages);
      return width / stages;
   endfunction
endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// The master side produces operands and consumes results; the slave side is the adder.
interface pipelined_addsub_if
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;

   modport master (
      output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf
   );
endinterface

// File: rtl/pipelined_addsub_rca_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from per-bit full-adder equations.
// Also exposes the carry into the chunk MSB so the last stage can derive signed overflow.
module rca_chunk
   import adder_pkg::*;
#(
   parameter int CHUNK = chunk_w(DEF_WIDTH, DEF_STAGES)
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);
   logic [CHUNK:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int i = 0; i < CHUNK; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout     = c[CHUNK];
   assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor: STAGES chunks, carry registered between chunks,
// valid/ready handshake where the whole pipe advances or holds as one.
module pipelined_addsub
   import adder_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input logic               clk,
   input logic               rst_n,
   pipelined_addsub_if.slave bus
);
   localparam int CHUNK = chunk_w(WIDTH, STAGES);

   logic             advance;

   logic             valid_q [STAGES];
   logic             valid_d [STAGES];
   logic             carry_q [STAGES];
   logic             carry_d [STAGES];
   logic             ovf_q   [STAGES];
   logic             ovf_d   [STAGES];
   logic [WIDTH-1:0] sum_q   [STAGES];
   logic [WIDTH-1:0] sum_d   [STAGES];
   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] a_d     [STAGES];
   logic [WIDTH-1:0] b_q     [STAGES];
   logic [WIDTH-1:0] b_d     [STAGES];

   logic             st_valid [STAGES];
   logic             st_c     [STAGES];
   logic [WIDTH-1:0] st_a     [STAGES];
   logic [WIDTH-1:0] st_b     [STAGES];
   logic [WIDTH-1:0] st_sum   [STAGES];

   logic [CHUNK-1:0] ch_sum  [STAGES];
   logic             ch_cout [STAGES];
   logic             ch_cmsb [STAGES];

   assign advance      = !valid_q[STAGES-1] || bus.out_ready;
   assign bus.in_ready = advance;

   // Stage 0 sees the conditioned operands; later stages see the previous stage's registers.
   always_comb begin : stage_inputs
      st_valid[0] = bus.in_valid;
      st_a[0]     = bus.in_a;
      st_b[0]     = bus.in_sub ? ~bus.in_b : bus.in_b;
      st_c[0]     = bus.in_sub ^ bus.in_cin;
      st_sum[0]   = '0;
      for (int k = 1; k < STAGES; k++) begin
         st_valid[k] = valid_q[k-1];
         st_a[k]     = a_q[k-1];
         st_b[k]     = b_q[k-1];
         st_c[k]     = carry_q[k-1];
         st_sum[k]   = sum_q[k-1];
      end
   end

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_chunk
         rca_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a        (st_a[gi][gi*CHUNK +: CHUNK]),
            .b        (st_b[gi][gi*CHUNK +: CHUNK]),
            .cin      (st_c[gi]),
            .sum      (ch_sum[gi]),
            .cout     (ch_cout[gi]),
            .c_msb_in (ch_cmsb[gi])
         );
      end
   endgenerate

   // Every stage holds unless the pipe advances; only the final stage's ovf is observed.
   always_comb begin : stage_next
      for (int k = 0; k < STAGES; k++) begin
         valid_d[k] = valid_q[k];
         carry_d[k] = carry_q[k];
         ovf_d[k]   = ovf_q[k];
         sum_d[k]   = sum_q[k];
         a_d[k]     = a_q[k];
         b_d[k]     = b_q[k];
      end
      if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_d[k]                  = st_valid[k];
            carry_d[k]                  = ch_cout[k];
            ovf_d[k]                    = ch_cout[k] ^ ch_cmsb[k];
            a_d[k]                      = st_a[k];
            b_d[k]                      = st_b[k];
            sum_d[k]                    = st_sum[k];
            sum_d[k][k*CHUNK +: CHUNK]  = ch_sum[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            carry_q[k] <= 1'b0;
            ovf_q[k]   <= 1'b0;
            sum_q[k]   <= '0;
            a_q[k]     <= '0;
            b_q[k]     <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= valid_d[k];
            carry_q[k] <= carry_d[k];
            ovf_q[k]   <= ovf_d[k];
            sum_q[k]   <= sum_d[k];
            a_q[k]     <= a_d[k];
            b_q[k]     <= b_d[k];
         end
      end
   end

   assign bus.out_valid = valid_q[STAGES-1];
   assign bus.out_sum   = sum_q[STAGES-1];
   assign bus.out_cout  = carry_q[STAGES-1];
   assign bus.out_ovf   = ovf_q[STAGES-1];
endmodule
